// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arbiter
//  Purpose  : Two-requester (CPU / debug) arbiter for the single data-memory
//             port. Serialises accesses, holds each one for LAT cycles,
//             returns load data with a one-cycle done pulse, and grants
//             round-robin when both requesters contend.
//  Revision : 1.0  initial release
// ============================================================================
module dm_arbiter #(
   parameter int LAT = 1,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_done,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_done,
   output logic          MemWrite,
   output logic [AW-1:0] Addr,
   output logic [DW-1:0] WD,
   input  logic [DW-1:0] RD,
   output logic          busy
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // Counter preload: the first BUSY cycle is the one where cnt equals this.
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
   localparam logic       GNT_CPU  = 1'b0;
   localparam logic       GNT_DBG  = 1'b1;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            last_gnt_q, last_gnt_d;
   logic            gnt_q, gnt_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
   logic            cpu_done_q, cpu_done_d;
   logic            dbg_done_q, dbg_done_d;

   // A requester in its done cycle is not eligible, so it is never re-granted
   // on the same cycle it is being told it has finished.
   logic w_cpu_elig;
   logic w_dbg_elig;
   logic w_pick_dbg;

   assign w_cpu_elig = cpu_req & ~cpu_done_q;
   assign w_dbg_elig = dbg_req & ~dbg_done_q;
   // Debug wins if it is alone, or on a tie when the CPU was served last.
   assign w_pick_dbg = w_dbg_elig & (~w_cpu_elig | (last_gnt_q == GNT_CPU));

   // State register and all latched access/response state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         last_gnt_q  <= GNT_DBG;
         gnt_q       <= GNT_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         cpu_done_q  <= 1'b0;
         dbg_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_gnt_q  <= last_gnt_d;
         gnt_q       <= gnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         cpu_done_q  <= cpu_done_d;
         dbg_done_q  <= dbg_done_d;
      end
   end

   // Next-state: grant/latch in IDLE, count down and complete in BUSY.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_gnt_d  = last_gnt_q;
      gnt_d       = gnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      cpu_done_d  = 1'b0;
      dbg_done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_cpu_elig || w_dbg_elig) begin
               gnt_d      = w_pick_dbg;
               last_gnt_d = w_pick_dbg;
               we_d       = w_pick_dbg ? dbg_we    : cpu_we;
               addr_d     = w_pick_dbg ? dbg_addr  : cpu_addr;
               wdata_d    = w_pick_dbg ? dbg_wdata : cpu_wdata;
               cnt_d      = CNT_INIT;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               if (gnt_q == GNT_CPU) begin
                  cpu_done_d = 1'b1;
                  if (!we_q) cpu_rdata_d = RD;
               end else begin
                  dbg_done_d = 1'b1;
                  if (!we_q) dbg_rdata_d = RD;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Memory port is driven from the latched access so it holds its last
   // values while idle; the write strobe is limited to the first BUSY cycle.
   assign busy      = (state_q == S_BUSY);
   assign MemWrite  = busy && (cnt_q == CNT_INIT) && we_q;
   assign Addr      = addr_q;
   assign WD        = wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign cpu_done  = cpu_done_q;
   assign dbg_done  = dbg_done_q;
   assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_arbiter
//  Purpose  : Directed self-checking bench for dm_arbiter; three instances
//             with LAT = 1, 3 and 4, each with its own stimulus and memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_arbiter;

   logic        clk;
   logic        rst       [3];
   logic        cpu_req   [3];
   logic        cpu_we    [3];
   logic [31:0] cpu_addr  [3];
   logic [31:0] cpu_wdata [3];
   logic [31:0] cpu_rdata [3];
   logic        cpu_done  [3];
   logic        cpu_stall [3];
   logic        dbg_req   [3];
   logic        dbg_we    [3];
   logic [31:0] dbg_addr  [3];
   logic [31:0] dbg_wdata [3];
   logic [31:0] dbg_rdata [3];
   logic        dbg_done  [3];
   logic        mem_write [3];
   logic [31:0] maddr     [3];
   logic [31:0] mwd       [3];
   logic [31:0] mrd       [3];
   logic        mbusy     [3];

   int checks   = 0;
   int failures = 0;

   // Combinational read-only memory contents.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hDEADBEEF;
         32'h30:  return 32'hCAFE0030;
         32'h40:  return 32'hBAD00040;
         default: return a ^ 32'hA5A50000;
      endcase
   endfunction

   genvar k;
   generate
      for (k = 0; k < 3; k++) begin : g_dut
         assign mrd[k] = mem_model(maddr[k]);
         dm_arbiter #(
            .LAT ((k == 0) ? 1 : ((k == 1) ? 3 : 4)),
            .AW  (32),
            .DW  (32)
         ) u_dut (
            .clk       (clk),
            .rst       (rst[k]),
            .cpu_req   (cpu_req[k]),
            .cpu_we    (cpu_we[k]),
            .cpu_addr  (cpu_addr[k]),
            .cpu_wdata (cpu_wdata[k]),
            .cpu_rdata (cpu_rdata[k]),
            .cpu_done  (cpu_done[k]),
            .cpu_stall (cpu_stall[k]),
            .dbg_req   (dbg_req[k]),
            .dbg_we    (dbg_we[k]),
            .dbg_addr  (dbg_addr[k]),
            .dbg_wdata (dbg_wdata[k]),
            .dbg_rdata (dbg_rdata[k]),
            .dbg_done  (dbg_done[k]),
            .MemWrite  (mem_write[k]),
            .Addr      (maddr[k]),
            .WD        (mwd[k]),
            .RD        (mrd[k]),
            .busy      (mbusy[k])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1;
         cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
         dbg_req[i] = 1'b0; dbg_we[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
      end
      tick();
      tick();

      // ---------------- reset values (LAT=1 instance) ----------------
      chk("rst_busy",     32'(mbusy[0]),     32'd0);
      chk("rst_memwrite", 32'(mem_write[0]), 32'd0);
      chk("rst_addr",     maddr[0],          32'd0);
      chk("rst_wd",       mwd[0],            32'd0);
      chk("rst_cpu_rd",   cpu_rdata[0],      32'd0);
      chk("rst_dbg_rd",   dbg_rdata[0],      32'd0);
      chk("rst_cpu_done", 32'(cpu_done[0]),  32'd0);
      chk("rst_dbg_done", 32'(dbg_done[0]),  32'd0);
      cpu_req[0] = 1'b1;
      #1;
      chk("rst_stall_follows_req", 32'(cpu_stall[0]), 32'd1);
      cpu_req[0] = 1'b0;
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      tick();

      // ---------------- LAT=1 CPU load ----------------
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10;
      #1;
      chk("ld1_c0_stall", 32'(cpu_stall[0]), 32'd1);
      chk("ld1_c0_busy",  32'(mbusy[0]),     32'd0);
      tick();
      chk("ld1_c1_busy",  32'(mbusy[0]),     32'd1);
      chk("ld1_c1_stall", 32'(cpu_stall[0]), 32'd1);
      chk("ld1_c1_done",  32'(cpu_done[0]),  32'd0);
      chk("ld1_c1_addr",  maddr[0],          32'h10);
      tick();
      chk("ld1_c2_done",  32'(cpu_done[0]),  32'd1);
      chk("ld1_c2_rdata", cpu_rdata[0],      32'hDEADBEEF);
      chk("ld1_c2_stall", 32'(cpu_stall[0]), 32'd0);
      chk("ld1_c2_busy",  32'(mbusy[0]),     32'd0);
      cpu_req[0] = 1'b0;
      tick();
      chk("ld1_c3_done",  32'(cpu_done[0]),  32'd0);
      chk("ld1_c3_hold",  cpu_rdata[0],      32'hDEADBEEF);

      // ---------------- LAT=3 CPU store ----------------
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b1; cpu_addr[1] = 32'h20; cpu_wdata[1] = 32'h12345678;
      #1;
      chk("st3_c0_mw", 32'(mem_write[1]), 32'd0);
      tick();
      chk("st3_c1_mw",   32'(mem_write[1]), 32'd1);
      chk("st3_c1_addr", maddr[1],          32'h20);
      chk("st3_c1_wd",   mwd[1],            32'h12345678);
      tick();
      chk("st3_c2_mw",   32'(mem_write[1]), 32'd0);
      chk("st3_c2_addr", maddr[1],          32'h20);
      chk("st3_c2_wd",   mwd[1],            32'h12345678);
      tick();
      chk("st3_c3_mw",   32'(mem_write[1]), 32'd0);
      chk("st3_c3_busy", 32'(mbusy[1]),     32'd1);
      chk("st3_c3_addr", maddr[1],          32'h20);
      chk("st3_c3_wd",   mwd[1],            32'h12345678);
      chk("st3_c3_done", 32'(cpu_done[1]),  32'd0);
      tick();
      chk("st3_c4_done",  32'(cpu_done[1]),  32'd1);
      chk("st3_c4_mw",    32'(mem_write[1]), 32'd0);
      chk("st3_c4_rdata", cpu_rdata[1],      32'd0);
      cpu_req[1] = 1'b0; cpu_we[1] = 1'b0;
      tick();

      // ---------------- LAT=3 mid-access input change ----------------
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h30;
      tick();
      chk("mid_c1_addr", maddr[1], 32'h30);
      tick();
      cpu_addr[1] = 32'h40; cpu_req[1] = 1'b0;
      #1;
      chk("mid_c2_addr",  maddr[1],          32'h30);
      chk("mid_c2_stall", 32'(cpu_stall[1]), 32'd0);
      tick();
      chk("mid_c3_addr", maddr[1],      32'h30);
      chk("mid_c3_busy", 32'(mbusy[1]), 32'd1);
      tick();
      chk("mid_c4_done",  32'(cpu_done[1]), 32'd1);
      chk("mid_c4_rdata", cpu_rdata[1],     32'hCAFE0030);
      tick();
      chk("mid_c5_done", 32'(cpu_done[1]), 32'd0);
      chk("mid_c5_busy", 32'(mbusy[1]),    32'd0);
      chk("mid_c5_addr", maddr[1],         32'h30);

      // ---------------- LAT=4 dbg load, then reset mid-access ----------------
      dbg_req[2] = 1'b1; dbg_we[2] = 1'b0; dbg_addr[2] = 32'h60;
      tick(); tick(); tick(); tick();
      chk("dbg4_c4_done", 32'(dbg_done[2]), 32'd0);
      tick();
      chk("dbg4_c5_done",  32'(dbg_done[2]), 32'd1);
      chk("dbg4_c5_rdata", dbg_rdata[2],     32'hA5A50060);
      dbg_req[2] = 1'b0;
      tick();
      dbg_req[2] = 1'b1; dbg_addr[2] = 32'h70;
      tick();
      chk("rmid_c1_busy", 32'(mbusy[2]), 32'd1);
      tick();
      rst[2] = 1'b1;
      tick();
      chk("rmid_busy",  32'(mbusy[2]),     32'd0);
      chk("rmid_mw",    32'(mem_write[2]), 32'd0);
      chk("rmid_rdata", dbg_rdata[2],      32'd0);
      chk("rmid_addr",  maddr[2],          32'd0);
      rst[2] = 1'b0; dbg_req[2] = 1'b0;
      for (int n = 0; n < 6; n++) begin
         chk("rmid_no_done", 32'(dbg_done[2]), 32'd0);
         tick();
      end

      // ---------------- LAT=3 contention, round-robin ----------------
      rst[1] = 1'b1;
      tick();
      rst[1] = 1'b0;
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h70;
      dbg_req[1] = 1'b1; dbg_we[1] = 1'b0; dbg_addr[1] = 32'h80;
      for (int n = 1; n <= 20; n++) begin
         tick();
         chk("rr_cpu_done", 32'(cpu_done[1]), 32'((n % 8) == 4));
         chk("rr_dbg_done", 32'(dbg_done[1]), 32'((n % 8) == 0));
         chk("rr_busy",     32'(mbusy[1]),    32'(((n - 1) % 4) != 3));
         chk("rr_addr",     maddr[1],         (((n - 1) / 4) % 2 == 0) ? 32'h70 : 32'h80);
      end
      cpu_req[1] = 1'b0; dbg_req[1] = 1'b0;
      tick();

      // ---------------- LAT=1 done-cycle re-request ----------------
      cpu_req[0] = 1'b1; cpu_addr[0] = 32'h10;
      tick();
      chk("rr1_c1_busy", 32'(mbusy[0]), 32'd1);
      tick();
      chk("rr1_c2_done", 32'(cpu_done[0]), 32'd1);
      chk("rr1_c2_busy", 32'(mbusy[0]),    32'd0);
      tick();
      chk("rr1_c3_busy",  32'(mbusy[0]),     32'd0);
      chk("rr1_c3_done",  32'(cpu_done[0]),  32'd0);
      chk("rr1_c3_stall", 32'(cpu_stall[0]), 32'd1);
      tick();
      chk("rr1_c4_busy", 32'(mbusy[0]), 32'd1);
      tick();
      chk("rr1_c5_done", 32'(cpu_done[0]), 32'd1);
      cpu_req[0] = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
